// File: rtl/warp_fetcher_pkg.sv
// Shared types for the warp fetch stage: instruction word, scheduler warp
// states, fetcher FSM states, default widths and the cache-line parity helper.

`ifndef PROGRAM_ADDR_WIDTH
`define PROGRAM_ADDR_WIDTH 8
`endif

package warp_fetcher_pkg;

    typedef logic [31:0] instruction_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        FETCHER_IDLE     = 2'd0,
        FETCHER_FETCHING = 2'd1,
        FETCHER_DONE     = 2'd2
    } fetcher_state_t;

    localparam int DEFAULT_PROGRAM_ADDR_WIDTH = `PROGRAM_ADDR_WIDTH;
    localparam int DEFAULT_CACHE_ENTRIES      = 16;

    // Even parity over an instruction word; a stored line whose parity no
    // longer matches its data is treated as a miss and refetched.
    function automatic logic instruction_parity(input instruction_t word);
        return ^word;
    endfunction

endpackage

// File: rtl/warp_fetcher_icache.sv
// Direct-mapped instruction cache for the fetch stage: one instruction per
// line, combinational lookup on the registered arrays, single-line fill and a
// whole-cache invalidate that takes priority over a same-cycle fill.

module warp_fetcher_icache
    import warp_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_PROGRAM_ADDR_WIDTH,
    parameter int ENTRIES    = DEFAULT_CACHE_ENTRIES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_address,
    output logic                  hit,
    output instruction_t          hit_data,
    input  logic                  fill_enable,
    input  logic [ADDR_WIDTH-1:0] fill_address,
    input  instruction_t          fill_data,
    input  logic                  invalidate
);

    localparam int INDEX_WIDTH = $clog2(ENTRIES);

    // Tags are kept at full address width (upper bits zero) so the
    // comparison stays well-formed even when the index consumes every pc bit.
    logic [ENTRIES-1:0]     valid_r;
    logic [ADDR_WIDTH-1:0]  tag_r    [ENTRIES];
    instruction_t           data_r   [ENTRIES];
    logic                   parity_r [ENTRIES];

    logic [INDEX_WIDTH-1:0] lookup_index_s;
    logic [ADDR_WIDTH-1:0]  lookup_tag_s;
    logic [INDEX_WIDTH-1:0] fill_index_s;
    logic [ADDR_WIDTH-1:0]  fill_tag_s;
    logic                   hit_s;
    instruction_t           hit_data_s;

    assign lookup_index_s = lookup_address[INDEX_WIDTH-1:0];
    assign lookup_tag_s   = lookup_address >> INDEX_WIDTH;
    assign fill_index_s   = fill_address[INDEX_WIDTH-1:0];
    assign fill_tag_s     = fill_address >> INDEX_WIDTH;

    // Lookup: hit needs a valid line, a tag match and intact parity.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = data_r[lookup_index_s];
        if (valid_r[lookup_index_s]
            && (tag_r[lookup_index_s] == lookup_tag_s)
            && (parity_r[lookup_index_s] == instruction_parity(data_r[lookup_index_s]))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    assign hit      = hit_s;
    assign hit_data = hit_data_s;

    // Valid bits: reset and invalidate clear all; invalidate beats a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (invalidate) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (fill_enable) begin
            valid_r[fill_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Line payload: tag, data and parity written on fill, never reset.
    always_ff @(posedge clk) begin
        if (fill_enable) begin
            tag_r[fill_index_s]    <= fill_tag_s;
            data_r[fill_index_s]   <= fill_data;
            parity_r[fill_index_s] <= instruction_parity(fill_data);
        end
    end

endmodule

// File: rtl/warp_fetcher.sv
// Per-warp instruction fetch stage. While the scheduler holds the warp in
// WARP_FETCH the instruction at pc is returned from the I-cache (1 cycle) or
// from program memory over a valid/ready port (2 + wait cycles), then held in
// FETCHER_DONE until the warp moves to WARP_DECODE.

module warp_fetcher
    import warp_fetcher_pkg::*;
#(
    parameter int PROGRAM_ADDR_WIDTH = DEFAULT_PROGRAM_ADDR_WIDTH,
    parameter int CACHE_ENTRIES      = DEFAULT_CACHE_ENTRIES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  warp_state_t                   warp_state,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] pc,
    input  logic                          cache_invalidate,
    output logic                          mem_read_valid,
    output logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic                          mem_read_ready,
    input  instruction_t                  mem_read_data,
    output fetcher_state_t                fetcher_state,
    output instruction_t                  instruction
);

    fetcher_state_t                state_r;
    fetcher_state_t                state_next_s;
    logic                          mem_read_valid_r;
    logic                          mem_read_valid_next_s;
    logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address_r;
    logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address_next_s;
    instruction_t                  instruction_r;
    instruction_t                  instruction_next_s;
    logic                          fill_enable_s;
    logic                          cache_hit_s;
    instruction_t                  cache_hit_data_s;

    warp_fetcher_icache #(
        .ADDR_WIDTH (PROGRAM_ADDR_WIDTH),
        .ENTRIES    (CACHE_ENTRIES)
    ) u_icache (
        .clk            (clk),
        .reset          (reset),
        .lookup_address (pc),
        .hit            (cache_hit_s),
        .hit_data       (cache_hit_data_s),
        .fill_enable    (fill_enable_s),
        .fill_address   (mem_read_address_r),
        .fill_data      (mem_read_data),
        .invalidate     (cache_invalidate)
    );

    // Next-state and next-output logic; everything holds unless a branch
    // below changes it. The fill always uses the latched request address.
    always_comb begin
        state_next_s            = state_r;
        mem_read_valid_next_s   = mem_read_valid_r;
        mem_read_address_next_s = mem_read_address_r;
        instruction_next_s      = instruction_r;
        fill_enable_s           = 1'b0;
        case (state_r)
            FETCHER_IDLE: begin
                mem_read_valid_next_s = 1'b0;
                if (warp_state == WARP_FETCH) begin
                    if (cache_hit_s) begin
                        instruction_next_s = cache_hit_data_s;
                        state_next_s       = FETCHER_DONE;
                    end else begin
                        mem_read_valid_next_s   = 1'b1;
                        mem_read_address_next_s = pc;
                        state_next_s            = FETCHER_FETCHING;
                    end
                end else begin
                    state_next_s = FETCHER_IDLE;
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    instruction_next_s    = mem_read_data;
                    fill_enable_s         = 1'b1;
                    mem_read_valid_next_s = 1'b0;
                    state_next_s          = FETCHER_DONE;
                end else begin
                    mem_read_valid_next_s = 1'b1;
                    state_next_s          = FETCHER_FETCHING;
                end
            end
            FETCHER_DONE: begin
                mem_read_valid_next_s = 1'b0;
                if (warp_state == WARP_DECODE) begin
                    state_next_s = FETCHER_IDLE;
                end else begin
                    state_next_s = FETCHER_DONE;
                end
            end
            default: begin
                mem_read_valid_next_s = 1'b0;
                state_next_s          = FETCHER_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= FETCHER_IDLE;
            mem_read_valid_r   <= 1'b0;
            mem_read_address_r <= {PROGRAM_ADDR_WIDTH{1'b0}};
            instruction_r      <= 32'h0000_0000;
        end else begin
            state_r            <= state_next_s;
            mem_read_valid_r   <= mem_read_valid_next_s;
            mem_read_address_r <= mem_read_address_next_s;
            instruction_r      <= instruction_next_s;
        end
    end

    assign fetcher_state    = state_r;
    assign mem_read_valid   = mem_read_valid_r;
    assign mem_read_address = mem_read_address_r;
    assign instruction      = instruction_r;

endmodule

// File: tb/tb_warp_fetcher.sv
// Directed self-checking bench for warp_fetcher: cold miss with memory wait
// states, hit, index conflict, DONE hold, invalidate against fill and hit,
// and reset in the middle of a fetch.

module tb_warp_fetcher;
    import warp_fetcher_pkg::*;

    localparam int AW = 8;

    logic           clk;
    logic           reset;
    warp_state_t    warp_state;
    logic [AW-1:0]  pc;
    logic           cache_invalidate;
    logic           mem_read_valid;
    logic [AW-1:0]  mem_read_address;
    logic           mem_read_ready;
    instruction_t   mem_read_data;
    fetcher_state_t fetcher_state;
    instruction_t   instruction;

    int checks_total;
    int checks_passed;

    warp_fetcher #(
        .PROGRAM_ADDR_WIDTH (AW),
        .CACHE_ENTRIES      (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .warp_state       (warp_state),
        .pc               (pc),
        .cache_invalidate (cache_invalidate),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outputs(input string tag, input fetcher_state_t st,
                                  input logic vld, input logic [AW-1:0] addr,
                                  input instruction_t instr);
        check_value({tag, ".state"}, 32'(fetcher_state), 32'(st));
        check_value({tag, ".valid"}, 32'(mem_read_valid), 32'(vld));
        check_value({tag, ".addr"},  32'(mem_read_address), 32'(addr));
        check_value({tag, ".instr"}, instruction, instr);
    endtask

    // Complete a pending memory read with the given data (ready high one cycle).
    task automatic serve(input instruction_t data);
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = 32'hDEAD_BEEF;
    endtask

    task automatic to_decode();
        warp_state = WARP_DECODE;
        tick();
        warp_state = WARP_IDLE;
    endtask

    initial begin
        checks_total     = 0;
        checks_passed    = 0;
        reset            = 1'b1;
        warp_state       = WARP_IDLE;
        pc               = 8'h00;
        cache_invalidate = 1'b0;
        mem_read_ready   = 1'b0;
        mem_read_data    = 32'hDEAD_BEEF;
        tick();
        tick();
        reset = 1'b0;
        expect_outputs("reset", FETCHER_IDLE, 1'b0, 8'h00, 32'h0000_0000);

        // Idle warp states leave the fetcher alone.
        warp_state = WARP_EXECUTE;
        tick();
        expect_outputs("idle_hold", FETCHER_IDLE, 1'b0, 8'h00, 32'h0000_0000);

        // 1: cold miss, three wait cycles, pc change ignored while fetching.
        warp_state = WARP_FETCH;
        pc         = 8'h05;
        tick();
        expect_outputs("miss05.req", FETCHER_FETCHING, 1'b1, 8'h05, 32'h0000_0000);
        pc = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_outputs("miss05.wait", FETCHER_FETCHING, 1'b1, 8'h05, 32'h0000_0000);
        end
        serve(32'hA000_1234);
        expect_outputs("miss05.done", FETCHER_DONE, 1'b0, 8'h05, 32'hA000_1234);
        to_decode();
        expect_outputs("miss05.idle", FETCHER_IDLE, 1'b0, 8'h05, 32'hA000_1234);

        // 2: repeat fetch hits in one cycle, no memory request.
        warp_state = WARP_FETCH;
        pc         = 8'h05;
        tick();
        expect_outputs("hit05", FETCHER_DONE, 1'b0, 8'h05, 32'hA000_1234);

        // 4: held in DONE under WARP_FETCH, instruction stable.
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_outputs("done_hold", FETCHER_DONE, 1'b0, 8'h05, 32'hA000_1234);
        end
        to_decode();
        check_value("hold.idle", 32'(fetcher_state), 32'(FETCHER_IDLE));

        // 3: conflicting tag evicts pc 0x05.
        warp_state = WARP_FETCH;
        pc         = 8'h15;
        tick();
        expect_outputs("miss15.req", FETCHER_FETCHING, 1'b1, 8'h15, 32'hA000_1234);
        serve(32'hB000_0015);
        expect_outputs("miss15.done", FETCHER_DONE, 1'b0, 8'h15, 32'hB000_0015);
        to_decode();
        warp_state = WARP_FETCH;
        pc         = 8'h05;
        tick();
        expect_outputs("evict05.req", FETCHER_FETCHING, 1'b1, 8'h05, 32'hB000_0015);
        serve(32'hA000_1234);
        to_decode();

        // Zero-wait miss: exactly two cycles from request to DONE.
        warp_state = WARP_FETCH;
        pc         = 8'h3A;
        tick();
        serve(32'h1234_003A);
        expect_outputs("miss3a.done", FETCHER_DONE, 1'b0, 8'h3A, 32'h1234_003A);
        to_decode();

        // 5: invalidate coinciding with the fill of 0x07.
        warp_state = WARP_FETCH;
        pc         = 8'h07;
        tick();
        cache_invalidate = 1'b1;
        serve(32'hC0C0_0007);
        cache_invalidate = 1'b0;
        expect_outputs("inv_fill.done", FETCHER_DONE, 1'b0, 8'h07, 32'hC0C0_0007);
        to_decode();
        warp_state = WARP_FETCH;
        tick();
        expect_outputs("inv_fill.miss07", FETCHER_FETCHING, 1'b1, 8'h07, 32'hC0C0_0007);
        serve(32'hC0C0_0007);
        to_decode();

        // Invalidate on an IDLE hit: hit served from pre-invalidate contents.
        warp_state       = WARP_FETCH;
        cache_invalidate = 1'b1;
        tick();
        cache_invalidate = 1'b0;
        expect_outputs("inv_hit.done", FETCHER_DONE, 1'b0, 8'h07, 32'hC0C0_0007);
        to_decode();
        warp_state = WARP_FETCH;
        tick();
        check_value("inv_hit.miss07", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        serve(32'hC0C0_0007);
        to_decode();

        // 6: cache 0x05, then reset while a fetch of 0x09 waits on memory.
        warp_state = WARP_FETCH;
        pc         = 8'h05;
        tick();
        serve(32'hA000_1234);
        to_decode();
        warp_state = WARP_FETCH;
        tick();
        check_value("pre_reset.hit05", 32'(fetcher_state), 32'(FETCHER_DONE));
        to_decode();
        warp_state = WARP_FETCH;
        pc         = 8'h09;
        tick();
        check_value("pre_reset.req", 32'(mem_read_valid), 32'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_outputs("mid_reset", FETCHER_IDLE, 1'b0, 8'h00, 32'h0000_0000);
        pc = 8'h05;
        tick();
        expect_outputs("post_reset.miss05", FETCHER_FETCHING, 1'b1, 8'h05, 32'h0000_0000);
        serve(32'hA000_1234);
        expect_outputs("post_reset.done", FETCHER_DONE, 1'b0, 8'h05, 32'hA000_1234);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
